seg_scan_rx: RTL

- Receive end of the multiplexed 7-segment scan bus: samples the digit-select and segment-data lines and rebuilds per-digit segment bytes.
- Decodes each byte back to a hex nibble plus decimal point, flags malformed selects and unknown glyphs, and pulses once per complete scan frame.
- Used as the loopback checker and as the input stage when a scanned display bus is forwarded between boards.

---
 rtl/seg_scan_pkg.sv | 38 +++
 rtl/seg_scan_rx_if.sv | 28 ++
 rtl/seg_stab_filter.sv | 38 +++
 rtl/seg_scan_rx.sv | 127 ++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared 7-segment glyph table and decode helper for the scan-bus receive
// and transmit sides.
package seg_scan_pkg;

   localparam logic [7:0]  SEG_BLANK = 8'hFF;
   localparam logic [31:0] SEL_NONE  = '1;

   // Active-low g..a patterns, indexed by the hex value they represent
   localparam logic [6:0] SEG_GLYPH [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {
      SLOT_BLANK,
      SLOT_DIGIT,
      SLOT_ILLEGAL
   } slot_kind_e;

   typedef struct packed {
      logic       bad;
      logic [3:0] hex;
   } seg_dec_t;

   function automatic seg_dec_t seg_decode(input logic [6:0] pat);
      seg_dec_t r;
      r.bad = 1'b1;
      r.hex = 4'hF;
      for (int i = 0; i < 16; i++) begin
         if (pat == SEG_GLYPH[i]) begin
            r.bad = 1'b0;
            r.hex = 4'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_rx_if.sv
// Scan-bus lines plus the per-digit results rebuilt by the receiver.
interface seg_scan_rx_if #(
   parameter int NUM_DIG = 3,
   parameter int SEL_W   = 6
);
   logic [SEL_W-1:0]     seg_sel_in;
   logic [7:0]           seg_data_in;
   logic [NUM_DIG*8-1:0] dig_raw;
   logic [NUM_DIG*4-1:0] dig_hex;
   logic [NUM_DIG-1:0]   dig_dp;
   logic [NUM_DIG-1:0]   dig_valid;
   logic [NUM_DIG-1:0]   dig_bad;
   logic                 frame_done;
   logic                 sel_err;
   logic                 timeout;

   modport master (
      output seg_sel_in, seg_data_in,
      input  dig_raw, dig_hex, dig_dp, dig_valid, dig_bad,
      input  frame_done, sel_err, timeout
   );

   modport slave (
      input  seg_sel_in, seg_data_in,
      output dig_raw, dig_hex, dig_dp, dig_valid, dig_bad,
      output frame_done, sel_err, timeout
   );
endinterface

// File: rtl/seg_stab_filter.sv
// Run-length filter on the registered (sel, data) sample; strobes once when a
// run reaches the required length.
module seg_stab_filter #(
   parameter int W          = 14,
   parameter int STABLE_CYC = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] smp,
   input  logic         clr,
   output logic         stable
);

   logic [W-1:0] prev_q;
   logic [3:0]   cnt_q;
   logic [3:0]   run;

   always_comb begin
      run = 4'd1;
      if (smp == prev_q) begin
         run = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
      end
   end

   // Equality (not >=) so a long stable run strobes exactly once
   assign stable = (run == 4'(STABLE_CYC));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q <= '1;
         cnt_q  <= 4'd0;
      end else begin
         prev_q <= smp;
         cnt_q  <= clr ? 4'd0 : run;
      end
   end

endmodule

// File: rtl/seg_scan_rx.sv
// Receive side of the multiplexed 7-segment scan bus: rebuilds per-digit bytes,
// decodes them, and reports frames, select errors and bus timeout.
module seg_scan_rx
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIG     = 3,
   parameter int SEL_W       = 6,
   parameter int SEL_BASE    = 5,
   parameter int STABLE_CYC  = 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input logic          clk,
   input logic          rst_n,
   seg_scan_rx_if.slave bus
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   logic [SEL_W-1:0]     s1_sel;
   logic [7:0]           s1_data;
   slot_kind_e           kind;
   logic [2:0]           idx;
   logic                 stable;
   logic                 accept;
   seg_dec_t             dec;
   logic [NUM_DIG-1:0]   mask_q;
   logic [NUM_DIG-1:0]   mask_next;

   logic [NUM_DIG*8-1:0] raw_q;
   logic [NUM_DIG*4-1:0] hex_q;
   logic [NUM_DIG-1:0]   dp_q;
   logic [NUM_DIG-1:0]   valid_q;
   logic [NUM_DIG-1:0]   bad_q;
   logic                 fd_q;
   logic                 se_q;
   logic                 to_q;
   logic [TO_W-1:0]      to_cnt;

   always_comb begin
      kind = SLOT_ILLEGAL;
      idx  = 3'd0;
      if (s1_sel == SEL_NONE[SEL_W-1:0]) begin
         kind = SLOT_BLANK;
      end else begin
         for (int k = 0; k < NUM_DIG; k++) begin
            if (s1_sel == ~(SEL_W'(1) << (SEL_BASE - k))) begin
               kind = SLOT_DIGIT;
               idx  = 3'(k);
            end
         end
      end
   end

   seg_stab_filter #(
      .W          (SEL_W + 8),
      .STABLE_CYC (STABLE_CYC)
   ) u_stab (
      .clk    (clk),
      .rst_n  (rst_n),
      .smp    ({s1_sel, s1_data}),
      .clr    (kind == SLOT_ILLEGAL),
      .stable (stable)
   );

   assign accept    = (kind == SLOT_DIGIT) && stable;
   assign dec       = seg_decode(s1_data[6:0]);
   assign mask_next = mask_q | (NUM_DIG'(1) << idx);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_sel  <= SEL_NONE[SEL_W-1:0];
         s1_data <= SEG_BLANK;
         raw_q   <= {NUM_DIG{SEG_BLANK}};
         hex_q   <= {NUM_DIG{4'hF}};
         dp_q    <= '0;
         valid_q <= '0;
         bad_q   <= '0;
         mask_q  <= '0;
         fd_q    <= 1'b0;
         se_q    <= 1'b0;
         to_q    <= 1'b0;
         to_cnt  <= TO_W'(TIMEOUT_CYC);
      end else begin
         s1_sel  <= bus.seg_sel_in;
         s1_data <= bus.seg_data_in;
         fd_q    <= 1'b0;
         se_q    <= (kind == SLOT_ILLEGAL);
         if (accept) begin
            for (int k = 0; k < NUM_DIG; k++) begin
               if (idx == 3'(k)) begin
                  raw_q[8*k +: 8] <= s1_data;
                  hex_q[4*k +: 4] <= dec.hex;
                  bad_q[k]        <= dec.bad;
                  dp_q[k]         <= ~s1_data[7];
                  valid_q[k]      <= 1'b1;
               end
            end
            if (mask_next == {NUM_DIG{1'b1}}) begin
               fd_q   <= 1'b1;
               mask_q <= '0;
            end else begin
               mask_q <= mask_next;
            end
            // Accept wins over a coincident terminal count
            to_cnt <= TO_W'(TIMEOUT_CYC);
            to_q   <= 1'b0;
         end else if (!to_q) begin
            if (to_cnt == TO_W'(1)) begin
               to_q    <= 1'b1;
               valid_q <= '0;
               mask_q  <= '0;
            end
            to_cnt <= to_cnt - TO_W'(1);
         end
      end
   end

   assign bus.dig_raw    = raw_q;
   assign bus.dig_hex    = hex_q;
   assign bus.dig_dp     = dp_q;
   assign bus.dig_valid  = valid_q;
   assign bus.dig_bad    = bad_q;
   assign bus.frame_done = fd_q;
   assign bus.sel_err    = se_q;
   assign bus.timeout    = to_q;

endmodule
